instr_fetch_cache: RTL and testbench
====================================

# instr_fetch_cache

Responder side of the loader's two-port instruction fetch interface. Serves the two `cache_bus` read ports from a direct-mapped, one-word-per-line instruction store. Misses are refilled one word at a time through a single request/ready port to backing memory. Sits between the instruction processer's loader and the memory subsystem.

## Interface
Parameters:
- `XLEN`, 32, address width in bits
- `SETS`, 64, number of lines; power of two, ≥2; `IDX = $clog2(SETS)`

Ports:
- `global_bus.clk`  in  1  clock; all state updates on rising edge
- `global_bus.reset`  in  1  reset, asynchronous, active-high
- `flush`  in  1  invalidate all lines
- `cache_bus[i].address`  in  XLEN  fetch byte address, port i ∈ {0,1}; word aligned
- `cache_bus[i].read`  in  1  fetch request, held with address until hit
- `cache_bus[i].data`  out  32  instruction word
- `cache_bus[i].hit`  out  1  data valid for the address sampled on the previous edge
- `mem_bus.address`  out  XLEN  refill word address
- `mem_bus.read`  out  1  refill request, held until ready
- `mem_bus.data`  in  32  refill word, valid with ready
- `mem_bus.ready`  in  1  single-cycle refill completion

## Operation
- Address split: index = `address[2+:IDX]`; tag = `address[XLEN-1:2+IDX]`; bits [1:0] ignored.
- Per line: valid bit, tag, and 32-bit word.
- Lookup, each edge, per port: if `read` and valid and tag match, then `hit`=1 and `data`=word. Otherwise `hit`=0 and `data`=0. Both ports are served in the same cycle, including the same line.
- FSM states:
  - `IDLE`: `mem_bus.read`=0. At an edge where a port has `read`=1 and misses, latch that address as `miss_addr` and go to `FETCH`. Port 0 has priority. If both ports miss the same word, one refill serves both.
  - `FETCH`: `mem_bus.read`=1, `mem_bus.address`={`miss_addr`[XLEN-1:2],2'b00}, held stable. At an edge with `ready`=1: write word, tag, and valid=1 (unless `drop` is set), clear `drop`, and go to `IDLE`.
- Lookup at the refill edge sees the old array contents. No same-cycle bypass.
- A second miss (the other port) is detected only after returning to `IDLE`. Refills are strictly serial.
- `flush` at an edge:
  - clears all valid bits;
  - in `FETCH`, sets `drop`, so the pending word is discarded and the FSM still completes the handshake;
  - forces `hit`=0 for lookups at that edge.
- `flush` and refill-`ready` on the same edge: the word is not written.
- Reset, mid-refill included: all valid=0, FSM=`IDLE`, `drop`=0. All outputs 0: `hit`, `data`, `mem_bus.read`, `mem_bus.address`. A `ready` arriving after reset is ignored.

## Timing
- Hit latency: request sampled at edge E, `hit`/`data` registered and valid after E.
- Miss:
  - miss detected at E0; `mem_bus.read` high from E0;
  - `ready` sampled at Ek, line written;
  - lookup hits at Ek+1, so `hit`=1 after Ek+1.
  - Penalty = memory latency + 1 cycle.
- Two distinct misses: second refill starts at Ek+1. Both ports hit no earlier than Ej+1 of the second refill.
- `mem_bus.address` changes only on an `IDLE`→`FETCH` edge.

## Configuration
- `INSTR_CACHE_PERF_EN` defined:
  - adds outputs `hit_count` and `miss_count` (32 bits each, saturating at 0xFFFF_FFFF, reset to 0);
  - `hit_count` increments by the number of ports hitting at an edge (0, 1 or 2);
  - `miss_count` increments by 1 per `IDLE`→`FETCH` transition.
- Undefined: the ports and counters do not exist. Functional behaviour is identical.

## Test plan
- Reset: hold reset 3 cycles, release. Then port0 reads 0x100 → `hit`=0, `mem_bus.read`=1, `mem_bus.address`=0x100. Before the request, all outputs are 0.
- Cold miss then hit: port0 reads 0x100; memory returns 0xDEADBEEF with `ready` 4 cycles later → one cycle after `ready`, `hit`=1 and `data`=0xDEADBEEF. A re-read next cycle hits with no memory request.
- Dual miss: port0 reads 0x200 and port1 reads 0x204 → refill 0x200 first, then 0x204. Each port's `hit` asserts one cycle after its own `ready`.
- Conflict eviction (SETS=64): fill 0x000, then read 0x100 (same index) → miss and refill. A subsequent read of 0x000 misses again.
- Flush during refill: `flush` asserted while `FETCH` is pending for 0x300; `ready` arrives → no line written. The held read re-misses and a new request for 0x300 is issued.
- With `INSTR_CACHE_PERF_EN`: 2 cold misses, then 5 cycles of both ports hitting → `miss_count`=2, `hit_count`=10.

Source files
------------

// File: rtl/instr_fetch_cache.sv
// instr_fetch_cache
//   Direct-mapped, one-word-per-line instruction store serving two fetch
//   ports. Misses are refilled one word at a time over a single
//   request/ready memory port. Refills are strictly serial, and port 0
//   wins when both ports miss.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   flush               invalidate all lines (discards an in-flight refill)
//   cacheN_address      fetch byte address (word aligned), N in {0,1}
//   cacheN_read         fetch request, held with address until hit
//   cacheN_data         instruction word, registered
//   cacheN_hit          data valid for the address sampled on the previous edge
//   mem_address         refill word address (bits [1:0] forced to zero)
//   mem_read            refill request, held until mem_ready
//   mem_data            refill word, valid with mem_ready
//   mem_ready           single-cycle refill completion
//   hit_count           (INSTR_CACHE_PERF_EN only) saturating port-hit counter
//   miss_count          (INSTR_CACHE_PERF_EN only) saturating refill counter
//
// Build option: define INSTR_CACHE_PERF_EN to add the performance counters.
module instr_fetch_cache #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SETS = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [XLEN-1:0] cache0_address,
  input  logic            cache0_read,
  output logic [31:0]     cache0_data,
  output logic            cache0_hit,
  input  logic [XLEN-1:0] cache1_address,
  input  logic            cache1_read,
  output logic [31:0]     cache1_data,
  output logic            cache1_hit,
  output logic [XLEN-1:0] mem_address,
  output logic            mem_read,
  input  logic [31:0]     mem_data,
  input  logic            mem_ready
`ifdef INSTR_CACHE_PERF_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAGW = XLEN - 2 - IDX;

  typedef enum logic {
    IDLE,
    FETCH
  } state_e;

  state_e state_q, state_d;

  // Line storage. Only the valid bits need reset; tag/word are gated by them.
  logic [SETS-1:0] valid_q, valid_d;
  logic [TAGW-1:0] tag_mem  [SETS];
  logic [31:0]     word_mem [SETS];

  logic [XLEN-1:0] miss_addr_q, miss_addr_d;
  logic            drop_q, drop_d;

  logic [1:0]      hit_q, hit_d;
  logic [31:0]     data_q [2];
  logic [31:0]     data_d [2];

  logic [XLEN-1:0] port_addr [2];
  logic [1:0]      port_read;
  logic [IDX-1:0]  port_idx  [2];
  logic [TAGW-1:0] port_tag  [2];
  logic [1:0]      port_miss;

  logic            wr_en;
  logic [IDX-1:0]  fill_idx;
  logic [TAGW-1:0] fill_tag;
  logic            refill_start;

  // Byte-offset bits never select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cache0_address[1:0], cache1_address[1:0]};

  always_comb begin
    port_addr[0] = cache0_address;
    port_addr[1] = cache1_address;
    port_read    = {cache1_read, cache0_read};
  end

  // Lookup against the current array contents; a refill landing on this
  // edge is not visible until the next one.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      port_idx[i]  = port_addr[i][2 +: IDX];
      port_tag[i]  = port_addr[i][XLEN-1 -: TAGW];
      hit_d[i]     = port_read[i] && valid_q[port_idx[i]] &&
                     (tag_mem[port_idx[i]] == port_tag[i]) && !flush;
      data_d[i]    = hit_d[i] ? word_mem[port_idx[i]] : '0;
      port_miss[i] = port_read[i] && !hit_d[i];
    end
  end

  assign fill_idx = miss_addr_q[2 +: IDX];
  assign fill_tag = miss_addr_q[XLEN-1 -: TAGW];

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    drop_d       = drop_q;
    wr_en        = 1'b0;
    refill_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (port_miss[0]) begin
          miss_addr_d  = {port_addr[0][XLEN-1:2], 2'b00};
          state_d      = FETCH;
          refill_start = 1'b1;
        end else if (port_miss[1]) begin
          miss_addr_d  = {port_addr[1][XLEN-1:2], 2'b00};
          state_d      = FETCH;
          refill_start = 1'b1;
        end
      end
      FETCH: begin
        if (flush) begin
          drop_d = 1'b1;
        end
        // A flush coinciding with ready also suppresses the write.
        if (mem_ready) begin
          wr_en   = !drop_q && !flush;
          drop_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[fill_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      drop_q      <= 1'b0;
      hit_q       <= '0;
      data_q[0]   <= '0;
      data_q[1]   <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
      drop_q      <= drop_d;
      hit_q       <= hit_d;
      data_q[0]   <= data_d[0];
      data_q[1]   <= data_d[1];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      word_mem[fill_idx] <= mem_data;
    end
  end

  assign cache0_hit  = hit_q[0];
  assign cache1_hit  = hit_q[1];
  assign cache0_data = data_q[0];
  assign cache1_data = data_q[1];
  assign mem_read    = (state_q == FETCH);
  assign mem_address = miss_addr_q;

`ifdef INSTR_CACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [1:0]  hit_inc;
  logic [32:0] hit_sum;

  always_comb begin
    hit_inc   = {1'b0, hit_d[0]} + {1'b0, hit_d[1]};
    hit_sum   = {1'b0, hit_cnt_q} + {31'b0, hit_inc};
    hit_cnt_d = hit_sum[32] ? '1 : hit_sum[31:0];
    miss_cnt_d = miss_cnt_q;
    if (refill_start && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic unused_refill_start;
  assign unused_refill_start = refill_start;
`endif

endmodule

// File: tb/tb_instr_fetch_cache.sv
// Self-checking bench for instr_fetch_cache: a table of per-cycle vectors
// (inputs driven on the falling edge, outputs checked 1 time unit after the
// rising edge) plus a hand-written two-miss / dual-hit sequence that also
// checks the performance counters when INSTR_CACHE_PERF_EN is defined.
module tb_instr_fetch_cache;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] a0 = '0;
  logic        r0 = 1'b0;
  logic [31:0] d0;
  logic        h0;
  logic [31:0] a1 = '0;
  logic        r1 = 1'b0;
  logic [31:0] d1;
  logic        h1;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [31:0] mem_data = '0;
  logic        mem_ready = 1'b0;
`ifdef INSTR_CACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_cache #(.XLEN(32), .SETS(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .cache0_address (a0),
    .cache0_read    (r0),
    .cache0_data    (d0),
    .cache0_hit     (h0),
    .cache1_address (a1),
    .cache1_read    (r1),
    .cache1_data    (d1),
    .cache1_hit     (h1),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_data       (mem_data),
    .mem_ready      (mem_ready)
`ifdef INSTR_CACHE_PERF_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  typedef struct {
    logic        rst, flush, r0;
    logic [31:0] a0;
    logic        r1;
    logic [31:0] a1;
    logic        rdy;
    logic [31:0] md;
    logic        eh0;
    logic [31:0] ed0;
    logic        eh1;
    logic [31:0] ed1;
    logic        emr;
    logic [31:0] ema;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst_i, input logic fl_i,
                     input logic r0_i, input logic [31:0] a0_i,
                     input logic r1_i, input logic [31:0] a1_i,
                     input logic rdy_i, input logic [31:0] md_i,
                     input logic eh0, input logic [31:0] ed0,
                     input logic eh1, input logic [31:0] ed1,
                     input logic emr, input logic [31:0] ema);
    vec_t v;
    v.rst = rst_i; v.flush = fl_i; v.r0 = r0_i; v.a0 = a0_i;
    v.r1 = r1_i; v.a1 = a1_i; v.rdy = rdy_i; v.md = md_i;
    v.eh0 = eh0; v.ed0 = ed0; v.eh1 = eh1; v.ed1 = ed1;
    v.emr = emr; v.ema = ema;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  // Waits (bounded) for a refill request, checks its address, then answers.
  task automatic refill(input int tag_id, input logic [31:0] exp_addr,
                        input logic [31:0] wdata);
    int n = 0;
    while (mem_read !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("refill_req", tag_id, {31'b0, mem_read}, 32'd1);
    chk("refill_addr", tag_id, mem_address, exp_addr);
    @(negedge clk);
    mem_ready = 1'b1;
    mem_data  = wdata;
    @(posedge clk); #1;
    chk("refill_done", tag_id, {31'b0, mem_read}, 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  initial begin
    //   rst flush r0 a0          r1 a1          rdy md             | h0 d0            h1 d1            mr ma
    add(H, L, L, 32'h000, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        L, 32'h000);
    add(H, L, L, 32'h000, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        L, 32'h000);
    add(H, L, L, 32'h000, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        L, 32'h000);
    // stray ready after reset is ignored
    add(L, L, L, 32'h000, L, 32'h000, H, 32'h1234,     L, 32'h0,        L, 32'h0,        L, 32'h000);
    // cold miss 0x100, ready 4 cycles after the miss edge
    add(L, L, H, 32'h100, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        H, 32'h100);
    add(L, L, H, 32'h100, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        H, 32'h100);
    add(L, L, H, 32'h100, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        H, 32'h100);
    add(L, L, H, 32'h100, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        H, 32'h100);
    add(L, L, H, 32'h100, L, 32'h000, H, 32'hDEADBEEF, L, 32'h0,        L, 32'h0,        L, 32'h100);
    add(L, L, H, 32'h100, L, 32'h000, L, 32'h0,        H, 32'hDEADBEEF, L, 32'h0,        L, 32'h100);
    // both ports on the same line
    add(L, L, H, 32'h100, H, 32'h100, L, 32'h0,        H, 32'hDEADBEEF, H, 32'hDEADBEEF, L, 32'h100);
    add(L, L, L, 32'h100, L, 32'h100, L, 32'h0,        L, 32'h0,        L, 32'h0,        L, 32'h100);
    // conflict eviction on index 0
    add(L, L, H, 32'h000, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        H, 32'h000);
    add(L, L, H, 32'h000, L, 32'h000, H, 32'h11110000, L, 32'h0,        L, 32'h0,        L, 32'h000);
    add(L, L, H, 32'h000, L, 32'h000, L, 32'h0,        H, 32'h11110000, L, 32'h0,        L, 32'h000);
    add(L, L, H, 32'h100, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        H, 32'h100);
    add(L, L, H, 32'h100, L, 32'h000, H, 32'hDEADBEEF, L, 32'h0,        L, 32'h0,        L, 32'h100);
    add(L, L, H, 32'h100, L, 32'h000, L, 32'h0,        H, 32'hDEADBEEF, L, 32'h0,        L, 32'h100);
    add(L, L, H, 32'h000, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        H, 32'h000);
    add(L, L, H, 32'h000, L, 32'h000, H, 32'h11110000, L, 32'h0,        L, 32'h0,        L, 32'h000);
    add(L, L, H, 32'h000, L, 32'h000, L, 32'h0,        H, 32'h11110000, L, 32'h0,        L, 32'h000);
    // dual miss: 0x200 first, then 0x204
    add(L, L, H, 32'h200, H, 32'h204, L, 32'h0,        L, 32'h0,        L, 32'h0,        H, 32'h200);
    add(L, L, H, 32'h200, H, 32'h204, H, 32'hAAAA0200, L, 32'h0,        L, 32'h0,        L, 32'h200);
    add(L, L, H, 32'h200, H, 32'h204, L, 32'h0,        H, 32'hAAAA0200, L, 32'h0,        H, 32'h204);
    add(L, L, H, 32'h200, H, 32'h204, L, 32'h0,        H, 32'hAAAA0200, L, 32'h0,        H, 32'h204);
    add(L, L, H, 32'h200, H, 32'h204, H, 32'hBBBB0204, H, 32'hAAAA0200, L, 32'h0,        L, 32'h204);
    add(L, L, H, 32'h200, H, 32'h204, L, 32'h0,        H, 32'hAAAA0200, H, 32'hBBBB0204, L, 32'h204);
    // flush during refill of 0x300: word dropped, re-miss
    add(L, L, H, 32'h300, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        H, 32'h300);
    add(L, H, H, 32'h300, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        H, 32'h300);
    add(L, L, H, 32'h300, L, 32'h000, H, 32'hCCCC0300, L, 32'h0,        L, 32'h0,        L, 32'h300);
    add(L, L, H, 32'h300, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        H, 32'h300);
    add(L, L, H, 32'h300, L, 32'h000, H, 32'hCCCC0300, L, 32'h0,        L, 32'h0,        L, 32'h300);
    add(L, L, H, 32'h300, L, 32'h000, L, 32'h0,        H, 32'hCCCC0300, L, 32'h0,        L, 32'h300);
    // idle flush invalidates 0x204; port 1 alone refills
    add(L, H, L, 32'h000, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        L, 32'h300);
    add(L, L, L, 32'h000, H, 32'h204, L, 32'h0,        L, 32'h0,        L, 32'h0,        H, 32'h204);
    add(L, L, L, 32'h000, H, 32'h204, H, 32'h12345678, L, 32'h0,        L, 32'h0,        L, 32'h204);
    add(L, L, L, 32'h000, H, 32'h204, L, 32'h0,        L, 32'h0,        H, 32'h12345678, L, 32'h204);
    // flush and ready on the same edge: no write
    add(L, L, H, 32'h100, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        H, 32'h100);
    add(L, H, H, 32'h100, L, 32'h000, H, 32'h00000055, L, 32'h0,        L, 32'h0,        L, 32'h100);
    add(L, L, H, 32'h100, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        H, 32'h100);
    add(L, L, H, 32'h100, L, 32'h000, H, 32'h00000066, L, 32'h0,        L, 32'h0,        L, 32'h100);
    add(L, L, H, 32'h100, L, 32'h000, L, 32'h0,        H, 32'h00000066, L, 32'h0,        L, 32'h100);
    // reset mid-refill, late ready ignored, lines invalidated
    add(L, L, H, 32'h204, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        H, 32'h204);
    add(H, L, L, 32'h000, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        L, 32'h000);
    add(L, L, L, 32'h000, L, 32'h000, H, 32'h00000077, L, 32'h0,        L, 32'h0,        L, 32'h000);
    add(L, L, H, 32'h100, L, 32'h000, L, 32'h0,        L, 32'h0,        L, 32'h0,        H, 32'h100);
    add(L, L, H, 32'h100, L, 32'h000, H, 32'h00000088, L, 32'h0,        L, 32'h0,        L, 32'h100);
    add(L, L, H, 32'h100, L, 32'h000, L, 32'h0,        H, 32'h00000088, L, 32'h0,        L, 32'h100);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; flush = vq[i].flush;
      r0 = vq[i].r0; a0 = vq[i].a0; r1 = vq[i].r1; a1 = vq[i].a1;
      mem_ready = vq[i].rdy; mem_data = vq[i].md;
      @(posedge clk); #1;
      chk("hit0", i, {31'b0, h0}, {31'b0, vq[i].eh0});
      chk("data0", i, d0, vq[i].ed0);
      chk("hit1", i, {31'b0, h1}, {31'b0, vq[i].eh1});
      chk("data1", i, d1, vq[i].ed1);
      chk("mem_read", i, {31'b0, mem_read}, {31'b0, vq[i].emr});
      chk("mem_addr", i, mem_address, vq[i].ema);
    end

    // Two cold misses, then five cycles of both ports hitting.
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; r0 = 1'b0; r1 = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
`ifdef INSTR_CACHE_PERF_EN
    chk("hit_count_rst", 0, hit_count, 32'd0);
    chk("miss_count_rst", 0, miss_count, 32'd0);
`endif
    r0 = 1'b1; a0 = 32'h400;
    refill(0, 32'h400, 32'h40404040);
    a0 = 32'h404;
    refill(1, 32'h404, 32'h40404044);
    a0 = 32'h400; r1 = 1'b1; a1 = 32'h404;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("seq_hit0", c, {31'b0, h0}, 32'd1);
      chk("seq_data0", c, d0, 32'h40404040);
      chk("seq_hit1", c, {31'b0, h1}, 32'd1);
      chk("seq_data1", c, d1, 32'h40404044);
      chk("seq_no_req", c, {31'b0, mem_read}, 32'd0);
      @(negedge clk);
    end
    r0 = 1'b0; r1 = 1'b0;
    @(posedge clk); #1;
`ifdef INSTR_CACHE_PERF_EN
    chk("hit_count", 0, hit_count, 32'd10);
    chk("miss_count", 0, miss_count, 32'd2);
`endif
    chk("seq_idle_hit0", 0, {31'b0, h0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
